// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer for a simple accumulator CPU.
// Phases INST_ADDR..STORE advance one per clock while En_cpu_in=1; HLT in
// OP_ADDR moves to a terminal HALTED state that only reset leaves.
// Optional feature: define CTRL_INSTR_COUNT_EN to add the 8-bit instr_count
// output, which counts completed STORE phases.
module cpu_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       En_cpu_in,
    input  logic [2:0] Opcode,
    input  logic       SKZ_cmp,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [7:0] instr_count
`endif
);

    localparam logic [2:0] OpHlt = 3'b000;
    localparam logic [2:0] OpSkz = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpLda = 3'b101;
    localparam logic [2:0] OpSto = 3'b110;
    localparam logic [2:0] OpJmp = 3'b111;

    // Low three bits of the running states equal the reported phase.
    typedef enum logic [3:0] {
        StInstAddr  = 4'd0,
        StInstFetch = 4'd1,
        StInstLoad  = 4'd2,
        StIdle      = 4'd3,
        StOpAddr    = 4'd4,
        StOpFetch   = 4'd5,
        StAluOp     = 4'd6,
        StStore     = 4'd7,
        StHalted    = 4'd8
    } state_e;

    state_e state;
    logic   aluop;
    logic   advance;

    assign aluop   = (Opcode == OpAdd) || (Opcode == OpAnd) ||
                     (Opcode == OpXor) || (Opcode == OpLda);
    assign advance = En_cpu_in && (state != StHalted);

    // Phase sequencer: step on enable, divert to HALTED on HLT in OP_ADDR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= StInstAddr;
        end else if (advance) begin
            if (state == StOpAddr && Opcode == OpHlt) begin
                state <= StHalted;
            end else begin
                state <= state_e'({1'b0, state[2:0] + 3'd1});
            end
        end
    end

`ifdef CTRL_INSTR_COUNT_EN
    // Count instructions retired through the STORE phase; wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_count <= 8'd0;
        end else if (advance && state == StStore) begin
            instr_count <= instr_count + 8'd1;
        end
    end
`endif

    // Moore decode of strobes from the current state and opcode.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = (state == StHalted) || (state == StOpAddr && Opcode == OpHlt);
        phase  = (state == StHalted) ? 3'd4 : state[2:0];
        // Strobes are suppressed while the sequencer is paused.
        if (En_cpu_in) begin
            unique case (state)
                StInstAddr: sel = 1'b1;
                StInstFetch: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                StInstLoad, StIdle: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                StOpAddr: inc_pc = 1'b1;
                StOpFetch: rd = aluop;
                StAluOp: begin
                    rd     = aluop;
                    inc_pc = (Opcode == OpSkz && SKZ_cmp) || (Opcode == OpJmp);
                    data_e = (Opcode == OpSto);
                end
                StStore: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (Opcode == OpJmp);
                    wr     = (Opcode == OpSto);
                    data_e = (Opcode == OpSto);
                end
                StHalted: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the driver pushes expected outputs
// from a phase-level reference model; a monitor pops and compares them.
// Define CTRL_INSTR_COUNT_EN to exercise the instruction counter as well.
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       En_cpu_in = 1'b0;
    logic [2:0] Opcode = 3'd0;
    logic       SKZ_cmp = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;
    logic [7:0] instr_count;

    cpu_controller dut (
        .clock      (clock),
        .reset      (reset),
        .En_cpu_in  (En_cpu_in),
        .Opcode     (Opcode),
        .SKZ_cmp    (SKZ_cmp),
        .sel        (sel),
        .rd         (rd),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .ld_ac      (ld_ac),
        .wr         (wr),
        .data_e     (data_e),
        .halt       (halt),
        .phase      (phase)
`ifdef CTRL_INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

`ifndef CTRL_INSTR_COUNT_EN
    assign instr_count = 8'd0;
`endif

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0] strobes;  // sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
        logic [2:0] ph;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done = 1'b0;

    // Reference model: instruction phase number, halted flag, retired count.
    int m_phase = 0;
    bit m_halted = 1'b0;
    int m_count = 0;

    function automatic exp_t model_out(input bit en, input logic [2:0] op, input bit skz);
        exp_t e;
        bit is_alu;
        bit s_sel, s_rd, s_ir, s_inc, s_ldpc, s_ldac, s_wr, s_de, s_halt;
        is_alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
        {s_sel, s_rd, s_ir, s_inc, s_ldpc, s_ldac, s_wr, s_de, s_halt} = '0;
        if (m_halted) begin
            s_halt = 1'b1;
        end else begin
            s_halt = (m_phase == 4) && (op == HLT);
            if (en) begin
                if (m_phase <= 3) begin
                    s_sel = 1'b1;
                    s_rd  = (m_phase >= 1);
                    s_ir  = (m_phase >= 2);
                end else if (m_phase == 4) begin
                    s_inc = 1'b1;
                end else begin
                    s_rd = is_alu;
                    if (m_phase == 6) begin
                        s_inc = (op == SKZ && skz) || (op == JMP);
                        s_de  = (op == STO);
                    end
                    if (m_phase == 7) begin
                        s_ldac = is_alu;
                        s_ldpc = (op == JMP);
                        s_wr   = (op == STO);
                        s_de   = (op == STO);
                    end
                end
            end
        end
        e.strobes = {s_sel, s_rd, s_ir, s_inc, s_ldpc, s_ldac, s_wr, s_de, s_halt};
        e.ph  = m_halted ? 3'd4 : 3'(m_phase);
        e.cnt = 8'(m_count % 256);
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, push expectation, then step the model.
    task automatic step(input bit en, input logic [2:0] op, input bit skz, input bit rst_n);
        @(negedge clock);
        En_cpu_in = en;
        Opcode    = op;
        SKZ_cmp   = skz;
        reset     = rst_n;
        if (!rst_n) begin
            m_phase  = 0;
            m_halted = 1'b0;
            m_count  = 0;
        end
        exp_q.push_back(model_out(en, op, skz));
        @(posedge clock);
        #1;
        if (rst_n && en && !m_halted) begin
            if (m_phase == 4 && op == HLT) begin
                m_halted = 1'b1;
            end else begin
                if (m_phase == 7) m_count++;
                m_phase = (m_phase + 1) % 8;
            end
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input bit skz);
        for (int i = 0; i < 8; i++) step(1'b1, op, skz, 1'b1);
    endtask

    // Monitor: compare the DUT against each queued expectation mid-cycle.
    initial begin : monitor
        exp_t e;
        logic [8:0] act;
        while (!done || exp_q.size() > 0) begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
                n_cmp++;
                if (act !== e.strobes) begin
                    n_err++;
                    $display("FAIL strobes @%0t: got %b expected %b (phase exp %0d)",
                             $time, act, e.strobes, e.ph);
                end
                n_cmp++;
                if (phase !== e.ph) begin
                    n_err++;
                    $display("FAIL phase @%0t: got %0d expected %0d", $time, phase, e.ph);
                end
                n_cmp++;
                if ((rd & wr) !== 1'b0 || (ld_pc & inc_pc) !== 1'b0) begin
                    n_err++;
                    $display("FAIL exclusive @%0t: rd/wr=%b%b ld_pc/inc_pc=%b%b expected no overlap",
                             $time, rd, wr, ld_pc, inc_pc);
                end
`ifdef CTRL_INSTR_COUNT_EN
                n_cmp++;
                if (instr_count !== e.cnt) begin
                    n_err++;
                    $display("FAIL instr_count @%0t: got %0d expected %0d",
                             $time, instr_count, e.cnt);
                end
`endif
            end
        end
    end

    initial begin : driver
        logic [2:0] op;
        // Reset held for two cycles.
        step(1'b1, ADD, 1'b0, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b0);
        // ADD, JMP, SKZ taken/not taken, STO instructions.
        run_instr(ADD, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b1);
        step(1'b1, ADD, 1'b0, 1'b0);
        run_instr(JMP, 1'b1);
        run_instr(SKZ, 1'b1);
        run_instr(SKZ, 1'b0);
        run_instr(STO, 1'b1);
        // HLT: halted for 20 cycles with enable toggling, then reset pulse.
        for (int i = 0; i < 5; i++) step(1'b1, HLT, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'($urandom), HLT, 1'($urandom), 1'b1);
        step(1'b1, HLT, 1'b0, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b1);
        // Pause in phase 3 for three cycles, then resume.
        for (int i = 0; i < 2; i++) step(1'b1, LDA, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, LDA, 1'($urandom), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, LDA, 1'b0, 1'b1);
`ifdef CTRL_INSTR_COUNT_EN
        // 256 more instructions bring the counter back around.
        step(1'b1, ADD, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) run_instr(3'($urandom_range(1, 7)), 1'($urandom));
`endif
        // Randomised traffic with rare halts and resets.
        for (int i = 0; i < 3000; i++) begin
            op = 3'($urandom);
            if (op == HLT && ($urandom % 16) != 0) op = XOR_;
            step(($urandom % 4) != 0, op, 1'($urandom), ($urandom % 64) != 0);
        end
        @(negedge clock);
        done = 1'b1;
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 En_cpu_in  input  1  1 = phase sequencer advances; 0 = phase held.
REQ-005 Opcode  input  3  instruction-register opcode: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-006 SKZ_cmp  input  1  accumulator-zero flag from the ALU.
REQ-007 sel  output  1  1 = memory address taken from the program counter, 0 = from the IR operand field.
REQ-008 rd  output  1  memory read strobe.
REQ-009 ld_ir  output  1  instruction-register load.
REQ-010 inc_pc  output  1  program-counter increment.
REQ-011 ld_pc  output  1  program-counter load from the IR address field (drives Load_in).
REQ-012 ld_ac  output  1  accumulator load.
REQ-013 wr  output  1  memory write strobe.
REQ-014 data_e  output  1  accumulator-to-data-bus driver enable.
REQ-015 halt  output  1  1 = CPU halted.
REQ-016 phase  output  3  current phase, 0-7.

Function
REQ-017 The block SHALL be an 8-phase state machine: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), plus a terminal HALTED state that reports phase=4.
REQ-018 While En_cpu_in=1 and the state is not HALTED, the phase SHALL advance by one per clock, wrapping from 7 to 0; while En_cpu_in=0, the phase SHALL hold and all strobes except halt SHALL be 0.
REQ-019 ALUOP is defined as Opcode in {ADD, AND, XOR, LDA}.
REQ-020 The outputs SHALL be Moore-style, decoded combinationally from the registered phase and Opcode with no added latency, per phase:
REQ-021 phases 0-3: sel=1; rd=1 in phases 1-3; ld_ir=1 in phases 2-3; all other strobes 0.
REQ-022 OP_ADDR: inc_pc=1; if Opcode=HLT, halt=1 and the next state SHALL be HALTED.
REQ-023 OP_FETCH: rd=ALUOP.
REQ-024 ALU_OP: rd=ALUOP; inc_pc=1 when (Opcode=SKZ and SKZ_cmp=1) or Opcode=JMP; data_e=1 when Opcode=STO.
REQ-025 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=1 when Opcode=JMP; wr=1 and data_e=1 when Opcode=STO.
REQ-026 In HALTED, halt SHALL be 1 and all other strobes 0; the state SHALL be left only through reset, regardless of En_cpu_in.
REQ-027 wr and rd SHALL never both be 1, and ld_pc and inc_pc SHALL never both be 1 in the same cycle.
REQ-028 SKZ_cmp SHALL be ignored in every phase other than ALU_OP.

Reset
REQ-029 While reset=0, the state SHALL be INST_ADDR and the outputs SHALL be: phase=0, sel=1 (when En_cpu_in=1), all other strobes 0, halt=0.
REQ-030 Reset asserted mid-instruction, including in HALTED, SHALL return the block to INST_ADDR immediately, with no pending strobes.
REQ-031 After reset deasserts, the first phase advance SHALL occur at the first rising edge at which En_cpu_in=1.

Configuration
REQ-032 With CTRL_INSTR_COUNT_EN defined, the block SHALL add the output instr_count[7:0], which resets to 0, increments once per STORE-phase advance, wraps from 255 to 0 and is unaffected by HALTED.
REQ-033 With CTRL_INSTR_COUNT_EN undefined, the instr_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario 1: reset=0 for 2 cycles, then En_cpu_in=1 with Opcode=ADD -> phases 0..7 in order; ld_ir=1 in phases 2-3; rd=1 and ld_ac=1 in phase 7; wrap to phase 0.
REQ-035 Scenario 2: Opcode=JMP -> inc_pc=1 in phase 6, ld_pc=1 in phase 7, wr=0 throughout.
REQ-036 Scenario 3: Opcode=SKZ with SKZ_cmp=1 -> inc_pc=1 in phase 6; repeated with SKZ_cmp=0 -> inc_pc=0 in phase 6.
REQ-037 Scenario 4: Opcode=STO -> data_e=1 in phases 6-7, wr=1 only in phase 7, rd=0 in phases 5-7.
REQ-038 Scenario 5: Opcode=HLT -> halt=1 from phase 4 onward and the state stays halted for 20 cycles; pulsing reset=0 -> phase=0 and halt=0.
REQ-039 Scenario 6: En_cpu_in dropped to 0 in phase 3 for 3 cycles -> phase stays 3 with strobes 0, then resumes at phase 4; with CTRL_INSTR_COUNT_EN defined, 256 instructions -> instr_count=0.
